irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Machine-level interrupt controller between the platform interrupt sources and the core trap unit.
- Synchronises raw lines laid out as interrupt_csr_t: MSI(3), MTI(7), MEI(11), UART0RX..GPIOC1(16..25).
- Latches edge-type sources, forms the mip view, masks it with mie and mstatus.MIE, and selects one winner by fixed priority.
- Presents the winner to the core over a req/ack handshake.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on every raw line (legal range 1..3).
- EDGE_MASK, 32'h03F0_0000, 1 marks a rising-edge-latched source and 0 a level source. The default makes GPIOA0..GPIOC1 edge-type. Bits outside VALID_MASK are ignored.
- VALID_MASK, 32'h03FF_0888, implemented interrupt bits. All other bits read 0 and never trap.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- irq_i  in  32  raw interrupt lines, interrupt_csr_t layout, asynchronous to clk
- mie  in  32  interrupt enable CSR
- mstatus_mie  in  1  global machine interrupt enable
- pend_clr  in  32  one-cycle software clear of latched edge-pending bits (mip write)
- mip  out  32  interrupt pending view, interrupt_csr_t layout
- trap_req  out  1  interrupt request to core
- trap_code  out  5  mcause exception code of the requested interrupt
- trap_ack  in  1  core has taken the trap (one-cycle pulse)

Behaviour:
- Reset (async, active-high):
  - sync flops, edge history, pending latches = 0
  - state = IDLE
  - mip = 0, trap_req = 0, trap_code = 0
- Synchronisation: each VALID bit passes SYNC_STAGES flops. Reserved bits are not synchronised and read 0.
- Level source:
  - mip bit = synchronised level.
  - Visible SYNC_STAGES cycles after the raw input is first sampled high.
- Edge source:
  - Pending sets on synchronised 0->1 (one history flop), so it is visible SYNC_STAGES+1 cycles after the raw rise.
  - Pending clears on pend_clr bit = 1, or on trap_ack while trap_code equals that bit index.
  - A set in the same cycle as a clear: set wins.
  - pend_clr on level bits has no effect.
- Eligible set = mip & mie & VALID_MASK, qualified by mstatus_mie.
- Priority, highest first: MEI(11), MSI(3), MTI(7), then 16, 17, ..., 25 (lower code first).
- FSM:
  - IDLE:
    - If eligible is nonzero: register winner code into trap_code, trap_req <= 1, go REQ.
    - trap_req rises 1 cycle after the eligible condition appears.
  - REQ:
    - trap_req = 1 and trap_code held stable; a newly pending higher-priority source does not preempt.
    - trap_ack = 1: clear the edge pending if applicable, trap_req <= 0, go HOLD. Ack has precedence over withdrawal in the same cycle.
    - Else, if the held source is no longer eligible (level dropped, mie bit cleared, pend_clr on it, or mstatus_mie = 0): trap_req <= 0, go IDLE (withdrawal).
  - HOLD: exactly one cycle, letting the core clear mstatus.MIE, then IDLE.
    - Minimum spacing between two trap_req assertions: 2 cycles after ack.
- trap_ack while not in REQ is ignored.
- trap_code keeps its last value when trap_req = 0.
- mip is registered; it never reflects pend_clr or ack in the same cycle.

Test Plan:
- Reset mid-REQ with MEI pending: assert rst -> trap_req = 0, mip = 0 immediately; after release with irq_i = 0, no request.
- Level MTI: mie[7] = 1, mstatus_mie = 1, irq_i[7] rises at cycle 0 -> mip[7] = 1 at cycle 2, trap_req = 1 with trap_code = 7 at cycle 3. Ack at cycle 5 -> trap_req = 0 at cycle 6; with MTI still high, trap_req returns at cycle 8.
- Edge GPIOA0: one-cycle pulse on irq_i[20] with mie = 0 -> mip[20] = 1 and stays latched. Enable mie[20] -> trap_req with trap_code = 20. After trap_ack -> mip[20] = 0 and no re-request.
- Priority: irq_i[16] and irq_i[11] high together, all enabled -> trap_code = 11. Raising irq_i[3] during REQ does not change the code. After ack, next code = 3, then 16.
- Withdrawal: level UART0TX (17) requesting, drop mstatus_mie before ack -> trap_req = 0 next cycle, FSM in IDLE, mip[17] still 1.
- Simultaneous set/clear: pend_clr[22] = 1 in the same cycle the synchronised GPIOB0 edge is detected -> mip[22] = 1. Writing a 1 to reserved bit 30 on irq_i -> mip[30] = 0, no trap.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-level interrupt controller.
// Synchronises raw interrupt lines, latches edge-type sources, builds the mip
// view, picks one enabled winner by fixed priority and hands it to the core
// over a req/ack handshake.
//
// state | meaning
// IDLE  | no request outstanding, looking for an eligible source
// REQ   | trap_req high, trap_code held until ack or withdrawal
// HOLD  | one cycle after ack so the core can clear mstatus.MIE
module irq_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EDGE_MASK   = 32'h03F0_0000,
  parameter logic [31:0] VALID_MASK  = 32'h03FF_0888
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] irq_i,
  input  logic [31:0] mie,
  input  logic        mstatus_mie,
  input  logic [31:0] pend_clr,
  output logic [31:0] mip,
  output logic        trap_req,
  output logic [4:0]  trap_code,
  input  logic        trap_ack
);

  localparam logic [31:0] EDGE_BITS  = EDGE_MASK & VALID_MASK;
  localparam logic [31:0] LEVEL_BITS = VALID_MASK & ~EDGE_MASK;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  logic [31:0] sync_q [SYNC_STAGES];
  logic [31:0] hist_q;
  logic [31:0] pend_q, pend_d;
  logic [31:0] sync_lvl;
  logic [31:0] rise;
  logic [31:0] ack_clr;
  logic [31:0] eligible;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [4:0]  code_q, code_d;

  // Fixed priority: MEI, MSI, MTI, then platform sources lowest index first.
  function automatic logic [4:0] pick_winner(input logic [31:0] e);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 25; i >= 16; i--) begin
      if (e[i]) c = 5'(i);
    end
    if (e[7])  c = 5'd7;
    if (e[3])  c = 5'd3;
    if (e[11]) c = 5'd11;
    return c;
  endfunction

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~hist_q & EDGE_BITS;
  assign ack_clr  = (state_q == REQ && trap_ack) ? (32'd1 << code_q) : 32'd0;
  // A new edge in the same cycle as a clear keeps the bit pending.
  assign pend_d   = ((pend_q & ~(pend_clr | ack_clr)) | rise) & EDGE_BITS;

  assign mip       = (sync_lvl & LEVEL_BITS) | pend_q;
  assign eligible  = mip & mie & VALID_MASK & {32{mstatus_mie}};
  assign trap_req  = req_q;
  assign trap_code = code_q;

  // Synchroniser chain, edge history and edge-pending latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
      pend_q <= '0;
    end else begin
      sync_q[0] <= irq_i & VALID_MASK;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_lvl;
      pend_q <= pend_d;
    end
  end

  // Handshake state and registered request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      code_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      code_q  <= code_d;
    end
  end

  // Next-state logic; ack wins over withdrawal, no preemption while in REQ.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (eligible != 32'd0) begin
          code_d  = pick_winner(eligible);
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (trap_ack) begin
          req_d   = 1'b0;
          state_d = HOLD;
        end else if (!eligible[code_q]) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with hand-computed expectations (SYNC_STAGES=2).
module tb_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] irq_i;
  logic [31:0] mie;
  logic        mstatus_mie;
  logic [31:0] pend_clr;
  logic [31:0] mip;
  logic        trap_req;
  logic [4:0]  trap_code;
  logic        trap_ack;

  int n_checks = 0;
  int n_pass   = 0;

  irq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .irq_i       (irq_i),
    .mie         (mie),
    .mstatus_mie (mstatus_mie),
    .pend_clr    (pend_clr),
    .mip         (mip),
    .trap_req    (trap_req),
    .trap_code   (trap_code),
    .trap_ack    (trap_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    trap_ack = 1'b1;
    tick(1);
    trap_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_i = '0; mie = '0; mstatus_mie = 1'b1;
    pend_clr = '0; trap_ack = 1'b0;
    tick(3);
    check("rst_mip", mip, 32'd0);
    check("rst_req", {31'd0, trap_req}, 32'd0);
    check("rst_code", {27'd0, trap_code}, 32'd0);
    rst = 1'b0;
    tick(1);

    // Level MTI timing and re-request spacing after ack.
    mie = 32'h0000_0080;
    irq_i = 32'h0000_0080;
    tick(1);
    check("mti_mip_c1", mip, 32'd0);
    tick(1);
    check("mti_mip_c2", mip, 32'h0000_0080);
    check("mti_req_c2", {31'd0, trap_req}, 32'd0);
    tick(1);
    check("mti_req_c3", {31'd0, trap_req}, 32'd1);
    check("mti_code", {27'd0, trap_code}, 32'd7);
    tick(1);
    ack_pulse();
    check("mti_req_after_ack", {31'd0, trap_req}, 32'd0);
    tick(1);
    check("mti_req_hold_gap", {31'd0, trap_req}, 32'd0);
    tick(1);
    check("mti_req_again", {31'd0, trap_req}, 32'd1);
    irq_i = '0; mie = '0;
    tick(1);
    check("mti_mie_withdraw", {31'd0, trap_req}, 32'd0);
    tick(4);

    // Edge GPIOA0: one-cycle pulse latched while disabled.
    irq_i = 32'h0010_0000;
    tick(1);
    irq_i = '0;
    tick(3);
    check("gpio_latched", mip, 32'h0010_0000);
    tick(3);
    check("gpio_still_latched", mip, 32'h0010_0000);
    check("gpio_no_req_masked", {31'd0, trap_req}, 32'd0);
    mie = 32'h0010_0000;
    tick(1);
    check("gpio_req", {31'd0, trap_req}, 32'd1);
    check("gpio_code", {27'd0, trap_code}, 32'd20);
    ack_pulse();
    check("gpio_mip_cleared", mip, 32'd0);
    tick(3);
    check("gpio_no_rereq", {31'd0, trap_req}, 32'd0);
    check("code_kept_idle", {27'd0, trap_code}, 32'd20);
    mie = '0;

    // Priority: MEI beats UART0RX, MSI does not preempt, then MSI, then 16.
    mie = 32'h0001_0808;
    irq_i = 32'h0001_0800;
    tick(3);
    check("prio_req", {31'd0, trap_req}, 32'd1);
    check("prio_code_mei", {27'd0, trap_code}, 32'd11);
    irq_i = 32'h0001_0808;
    tick(3);
    check("prio_no_preempt", {27'd0, trap_code}, 32'd11);
    mie = 32'h0001_0008;
    ack_pulse();
    tick(2);
    check("prio_next_req", {31'd0, trap_req}, 32'd1);
    check("prio_code_msi", {27'd0, trap_code}, 32'd3);
    mie = 32'h0001_0000;
    ack_pulse();
    tick(2);
    check("prio_code_16", {27'd0, trap_code}, 32'd16);
    irq_i = '0; mie = '0;
    tick(5);

    // Withdrawal by global disable.
    mie = 32'h0002_0000;
    irq_i = 32'h0002_0000;
    tick(3);
    check("wd_req", {31'd0, trap_req}, 32'd1);
    check("wd_code", {27'd0, trap_code}, 32'd17);
    mstatus_mie = 1'b0;
    tick(1);
    check("wd_req_dropped", {31'd0, trap_req}, 32'd0);
    check("wd_mip_kept", mip, 32'h0002_0000);
    tick(2);
    mstatus_mie = 1'b1;
    tick(1);
    check("wd_back_from_idle", {31'd0, trap_req}, 32'd1);
    mie = '0;
    tick(2);
    // pend_clr on a level bit has no effect.
    pend_clr = 32'h0002_0000;
    tick(1);
    pend_clr = '0;
    check("level_pend_clr", mip, 32'h0002_0000);
    irq_i = '0;
    tick(4);

    // Set and clear of GPIOB0 in the same cycle: set wins.
    irq_i = 32'h0040_0000;
    tick(2);
    pend_clr = 32'h0040_0000;
    tick(1);
    pend_clr = '0;
    check("setclr_set_wins", mip, 32'h0040_0000);
    pend_clr = 32'h0040_0000;
    tick(1);
    pend_clr = '0;
    check("setclr_then_clear", mip, 32'd0);
    tick(2);
    check("setclr_no_reset_on_high", mip, 32'd0);

    // Reserved bit never appears.
    irq_i = 32'h4000_0000;
    mie = 32'hFFFF_FFFF;
    tick(5);
    check("reserved_mip", mip, 32'd0);
    check("reserved_no_req", {31'd0, trap_req}, 32'd0);

    // Reset in the middle of a request.
    irq_i = 32'h0000_0800;
    mie = 32'h0000_0800;
    tick(3);
    check("rstmid_req_before", {31'd0, trap_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_req_async", {31'd0, trap_req}, 32'd0);
    check("rstmid_mip_async", mip, 32'd0);
    irq_i = '0;
    tick(1);
    rst = 1'b0;
    tick(5);
    check("rstmid_no_req_after", {31'd0, trap_req}, 32'd0);
    check("rstmid_mip_after", mip, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
